// File: rtl/inst_mem_loader.sv
// Byte-stream instruction memory loader: packs LE bytes into 32-bit words, writes them at +4 steps, stalls fetch while busy.
// Optional INST_LOADER_CHECKSUM_EN adds a trailing 4-byte checksum phase (CHECK state) and the chk_err output.
module inst_mem_loader #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              stall_pipeline_o,
  output logic              busy,
  output logic              done,
`ifdef INST_LOADER_CHECKSUM_EN
  output logic              chk_err,
`endif
  output logic [CNT_W-1:0]  words_written
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WRITE   = 3'd2,
    S_DONE    = 3'd3
`ifdef INST_LOADER_CHECKSUM_EN
   ,S_CHECK   = 3'd4
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       asm_q, asm_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] off_q, off_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  words_q, words_d;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [31:0]       sum_q, sum_d;
  logic              chk_err_q, chk_err_d;
`endif

  logic              xfer;
  logic              last_lane;
  logic [31:0]       asm_new;
  logic [CNT_W-1:0]  words_inc;

  assign xfer      = byte_valid && byte_ready;
  assign last_lane = (lane_q == 2'd3);
  assign words_inc = words_q + CNT_W'(1);

  always_comb begin
    asm_new = asm_q;
    asm_new[{lane_q, 3'b000} +: 8] = byte_data;
  end

  // State register, plus the datapath registers it sequences.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      lane_q    <= '0;
      asm_q     <= '0;
      base_q    <= '0;
      off_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      words_q   <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
      sum_q     <= '0;
      chk_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      asm_q     <= asm_d;
      base_q    <= base_d;
      off_q     <= off_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      words_q   <= words_d;
`ifdef INST_LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
      chk_err_q <= chk_err_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (word_count == '0) begin
`ifdef INST_LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      S_COLLECT: if (xfer && last_lane) state_d = S_WRITE;
      S_WRITE: begin
        if (words_inc == cnt_q) begin
`ifdef INST_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_COLLECT;
        end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      S_CHECK: if (xfer && last_lane) state_d = S_DONE;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state; the output registers only load on the 4th byte so they hold between writes.
  always_comb begin
    lane_d    = lane_q;
    asm_d     = asm_q;
    base_d    = base_q;
    off_d     = off_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    words_d   = words_q;
`ifdef INST_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
    chk_err_d = chk_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d    = base_addr & ~ADDR_W'(3);
          cnt_d     = word_count;
          words_d   = '0;
          lane_d    = '0;
          asm_d     = '0;
          off_d     = '0;
`ifdef INST_LOADER_CHECKSUM_EN
          sum_d     = '0;
          chk_err_d = 1'b0;
`endif
        end
      end
      S_COLLECT: begin
        if (xfer) begin
          lane_d = lane_q + 2'd1;
          asm_d  = asm_new;
          if (last_lane) begin
            wdata_d = asm_new;
            addr_d  = base_q + off_q;
          end
        end
      end
      S_WRITE: begin
        words_d = words_inc;
        off_d   = off_q + ADDR_W'(4);
        lane_d  = '0;
`ifdef INST_LOADER_CHECKSUM_EN
        sum_d   = sum_q + wdata_q;
`endif
      end
`ifdef INST_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (xfer) begin
          lane_d = lane_q + 2'd1;
          asm_d  = asm_new;
          if (last_lane) chk_err_d = (sum_q != asm_new);
        end
      end
`endif
      default: ;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    done       = 1'b0;
    busy       = (state_q != S_IDLE);
    case (state_q)
      S_COLLECT: byte_ready = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
      S_CHECK:   byte_ready = 1'b1;
`endif
      S_WRITE:   mem_we     = 1'b1;
      S_DONE:    done       = 1'b1;
      default: ;
    endcase
  end

  assign stall_pipeline_o = busy;
  assign mem_addr         = addr_q;
  assign mem_wdata        = wdata_q;
  assign words_written    = words_q;
`ifdef INST_LOADER_CHECKSUM_EN
  assign chk_err          = chk_err_q;
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: randomized and directed loads checked against a word/address list model.
module tb_inst_mem_loader;

`ifdef INST_LOADER_CHECKSUM_EN
  localparam int CHK_BYTES = 4;
`else
  localparam int CHK_BYTES = 0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready, mem_we, stall_pipeline_o, busy, done;
  logic [31:0] mem_addr, mem_wdata;
  logic [15:0] words_written;
`ifdef INST_LOADER_CHECKSUM_EN
  logic        chk_err;
  logic        done_chk;
`endif

  inst_mem_loader #(.ADDR_W(32), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .stall_pipeline_o(stall_pipeline_o), .busy(busy), .done(done),
`ifdef INST_LOADER_CHECKSUM_EN
    .chk_err(chk_err),
`endif
    .words_written(words_written)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0]  stream[$];
  logic [31:0] wr_addr[$], wr_data[$], exp_addr[$], exp_data[$];
  int  done_cnt, lat_err, stall_err, stall_cyc, hs_total;
  bit  hs_prev, timed_out, inject;

  // Observer: logs writes and flags a write not immediately preceded by a word-completing handshake.
  always @(negedge clock) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      if (!(hs_prev && (hs_total % 4 == 0))) lat_err++;
    end
    if (done) begin
      done_cnt++;
`ifdef INST_LOADER_CHECKSUM_EN
      done_chk = chk_err;
`endif
    end
    if (stall_pipeline_o !== busy) stall_err++;
    if (stall_pipeline_o) stall_cyc++;
    hs_prev = byte_valid && byte_ready;
    if (hs_prev) hs_total++;
  end

  task automatic add_chk(input bit corrupt);
    logic [31:0] sum;
    sum = '0;
    for (int i = 0; i < stream.size() / 4; i++)
      sum += {stream[4*i+3], stream[4*i+2], stream[4*i+1], stream[4*i]};
    if (corrupt) sum += 32'd1;
    for (int k = 0; k < CHK_BYTES; k++) stream.push_back(8'(sum >> (8 * k)));
  endtask

  task automatic build_expect(input logic [31:0] b, input int cnt);
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < cnt; i++) begin
      exp_addr.push_back((b & 32'hFFFF_FFFC) + 32'(4 * i));
      exp_data.push_back({stream[4*i+3], stream[4*i+2], stream[4*i+1], stream[4*i]});
    end
  endtask

  task automatic clear_obs();
    wr_addr.delete(); wr_data.delete();
    done_cnt = 0; lat_err = 0; stall_err = 0; stall_cyc = 0; hs_total = 0; timed_out = 0;
  endtask

  // gap: 0 = back-to-back, 1 = valid toggles every cycle, 2 = random valid
  task automatic run_load(input logic [31:0] b, input logic [15:0] cnt, input int gap);
    int idx, budget;
    bit v, acc, ph;
    clear_obs();
    base_addr = b; word_count = cnt; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    idx = 0; budget = 0; ph = 1'b0;
    while (idx < stream.size() && budget < 4000) begin
      case (gap)
        0:       v = 1'b1;
        1:       begin v = ph; ph = !ph; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      byte_valid = v;
      byte_data  = v ? stream[idx] : 8'($urandom);
      if (inject && idx == 2) begin start = 1'b1; base_addr = 32'h40; word_count = 16'd7; end
      acc = v && byte_ready;
      @(posedge clock); #1;
      start = 1'b0; base_addr = b; word_count = cnt;
      if (acc) idx++;
      budget++;
    end
    byte_valid = 1'b0;
    budget = 0;
    while (busy && budget < 50) begin @(posedge clock); #1; budget++; end
    if (busy || idx < stream.size()) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if ({byte_ready, mem_we, stall_pipeline_o, busy, done} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {byte_ready, mem_we, stall_pipeline_o, busy, done});
    end
    n_checks++;
    if ({mem_addr, mem_wdata, words_written} !== 80'h0) begin
      n_fail++; $display("FAIL reset_data: got %h %h %h expected zeros", mem_addr, mem_wdata, words_written);
    end
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_basic();
    stream = {8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h21, 8'h00};
    add_chk(1'b0);
    run_load(32'h100, 16'd2, 0);
    n_checks++;
    if (wr_addr.size() !== 2) begin n_fail++; $display("FAIL basic_nwr: got %0d expected 2", wr_addr.size()); end
    else begin
      n_checks++;
      if (wr_addr[0] !== 32'h100 || wr_data[0] !== 32'h00000013) begin
        n_fail++; $display("FAIL basic_w0: got %h@%h expected 00000013@00000100", wr_data[0], wr_addr[0]);
      end
      n_checks++;
      if (wr_addr[1] !== 32'h104 || wr_data[1] !== 32'h002100B3) begin
        n_fail++; $display("FAIL basic_w1: got %h@%h expected 002100b3@00000104", wr_data[1], wr_addr[1]);
      end
    end
    n_checks++;
    if (done_cnt !== 1 || timed_out) begin n_fail++; $display("FAIL basic_done: got %0d pulses timeout=%0d expected 1 0", done_cnt, timed_out); end
    n_checks++;
    if (words_written !== 16'd2) begin n_fail++; $display("FAIL basic_words: got %0d expected 2", words_written); end
    n_checks++;
    if (stall_cyc !== 11 + CHK_BYTES || stall_err !== 0) begin
      n_fail++; $display("FAIL basic_stall: got %0d cycles %0d mismatches expected %0d 0", stall_cyc, stall_err, 11 + CHK_BYTES);
    end
    n_checks++;
    if (lat_err !== 0) begin n_fail++; $display("FAIL basic_latency: got %0d late writes expected 0", lat_err); end
  endtask

  task automatic test_zero_count();
`ifdef INST_LOADER_CHECKSUM_EN
    stream.delete();
    add_chk(1'b0);
    run_load(32'h80, 16'd0, 0);
    n_checks++;
    if (wr_addr.size() !== 0 || done_cnt !== 1 || done_chk !== 1'b0) begin
      n_fail++; $display("FAIL zero_chk: got %0d writes %0d done chk_err=%b expected 0 1 0", wr_addr.size(), done_cnt, done_chk);
    end
`else
    clear_obs();
    base_addr = 32'h80; word_count = 16'd0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || byte_ready !== 1'b0) begin
      n_fail++; $display("FAIL zero_done: got done=%b ready=%b expected 1 0", done, byte_ready);
    end
    @(posedge clock); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_after: got done=%b busy=%b expected 0 0", done, busy);
    end
    n_checks++;
    if (wr_addr.size() !== 0 || done_cnt !== 1 || words_written !== 16'd0) begin
      n_fail++; $display("FAIL zero_writes: got %0d writes %0d done words=%0d expected 0 1 0", wr_addr.size(), done_cnt, words_written);
    end
`endif
  endtask

  task automatic test_gaps();
    stream = {8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h21, 8'h00};
    add_chk(1'b0);
    run_load(32'h100, 16'd2, 1);
    n_checks++;
    if (wr_addr.size() !== 2) begin n_fail++; $display("FAIL gaps_nwr: got %0d expected 2", wr_addr.size()); end
    else begin
      n_checks++;
      if (wr_data[0] !== 32'h00000013 || wr_data[1] !== 32'h002100B3 || wr_addr[1] !== 32'h104) begin
        n_fail++; $display("FAIL gaps_data: got %h %h@%h expected 00000013 002100b3@00000104", wr_data[0], wr_data[1], wr_addr[1]);
      end
    end
    n_checks++;
    if (lat_err !== 0 || done_cnt !== 1 || timed_out) begin
      n_fail++; $display("FAIL gaps_timing: got late=%0d done=%0d timeout=%0d expected 0 1 0", lat_err, done_cnt, timed_out);
    end
  endtask

  task automatic test_mid_reset();
    clear_obs();
    base_addr = 32'h0; word_count = 16'd1; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    byte_valid = 1'b1; byte_data = 8'h11;
    @(posedge clock); #1;
    byte_data = 8'h22;
    @(posedge clock); #1;
    byte_valid = 1'b0; reset = 1'b0;
    @(posedge clock); #1;
    n_checks++;
    if ({byte_ready, mem_we, stall_pipeline_o, busy, done} !== 5'b0 || {mem_addr, mem_wdata, words_written} !== 80'h0) begin
      n_fail++; $display("FAIL midrst_out: got ctrl=%b addr=%h data=%h words=%0d expected zeros",
                         {byte_ready, mem_we, stall_pipeline_o, busy, done}, mem_addr, mem_wdata, words_written);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if (wr_addr.size() !== 0) begin n_fail++; $display("FAIL midrst_nowrite: got %0d writes expected 0", wr_addr.size()); end
    stream = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    add_chk(1'b0);
    run_load(32'h0, 16'd1, 0);
    n_checks++;
    if (wr_addr.size() !== 1 || wr_data[0] !== 32'hDDCCBBAA || wr_addr[0] !== 32'h0) begin
      n_fail++; $display("FAIL midrst_reload: got %0d writes first %h@%h expected 1 ddccbbaa@00000000",
                         wr_addr.size(), wr_data[0], wr_addr[0]);
    end
  endtask

  task automatic test_wrap();
    stream.delete();
    for (int i = 0; i < 8; i++) stream.push_back(8'($urandom));
    add_chk(1'b0);
    build_expect(32'hFFFF_FFFE, 2);
    inject = 1'b1;
    run_load(32'hFFFF_FFFE, 16'd2, 0);
    inject = 1'b0;
    n_checks++;
    if (wr_addr.size() !== 2) begin n_fail++; $display("FAIL wrap_nwr: got %0d expected 2", wr_addr.size()); end
    else begin
      n_checks++;
      if (wr_addr[0] !== 32'hFFFF_FFFC || wr_addr[1] !== 32'h0) begin
        n_fail++; $display("FAIL wrap_addr: got %h %h expected fffffffc 00000000", wr_addr[0], wr_addr[1]);
      end
      n_checks++;
      if (wr_data[0] !== exp_data[0] || wr_data[1] !== exp_data[1]) begin
        n_fail++; $display("FAIL wrap_data: got %h %h expected %h %h", wr_data[0], wr_data[1], exp_data[0], exp_data[1]);
      end
    end
    n_checks++;
    if (words_written !== 16'd2 || done_cnt !== 1) begin
      n_fail++; $display("FAIL wrap_count: got words=%0d done=%0d expected 2 1", words_written, done_cnt);
    end
  endtask

  task automatic test_random();
    int cnt, gap;
    logic [31:0] b;
    for (int it = 0; it < 6; it++) begin
      cnt = $urandom_range(1, 5);
      gap = $urandom_range(0, 2);
      b   = $urandom;
      stream.delete();
      for (int i = 0; i < 4 * cnt; i++) stream.push_back(8'($urandom));
      add_chk(1'b0);
      build_expect(b, cnt);
      run_load(b, 16'(cnt), gap);
      n_checks++;
      if (wr_addr.size() !== exp_addr.size() || timed_out) begin
        n_fail++; $display("FAIL rand%0d_nwr: got %0d timeout=%0d expected %0d 0", it, wr_addr.size(), timed_out, exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
        n_checks++;
        if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
          n_fail++; $display("FAIL rand%0d_w%0d: got %h@%h expected %h@%h", it, i, wr_data[i], wr_addr[i], exp_data[i], exp_addr[i]);
        end
      end
      n_checks++;
      if (lat_err !== 0 || stall_err !== 0 || done_cnt !== 1 || words_written !== 16'(cnt)) begin
        n_fail++; $display("FAIL rand%0d_ctl: got late=%0d stall=%0d done=%0d words=%0d expected 0 0 1 %0d",
                           it, lat_err, stall_err, done_cnt, words_written, cnt);
      end
    end
  endtask

`ifdef INST_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    for (int bad = 0; bad < 2; bad++) begin
      stream = {8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
      add_chk(bad[0]);
      done_chk = 1'bx;
      run_load(32'h200, 16'd2, 0);
      n_checks++;
      if (done_chk !== bad[0] || chk_err !== bad[0]) begin
        n_fail++; $display("FAIL chk%0d: got at_done=%b after=%b expected %b", bad, done_chk, chk_err, bad[0]);
      end
    end
  endtask
`endif

  initial begin
    inject = 1'b0;
    clear_obs();
    test_reset();
    test_basic();
    test_zero_count();
    test_gaps();
    test_mid_reset();
    test_wrap();
    test_random();
`ifdef INST_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
